// File: rtl/serial_adder_subtractor.sv
// Bit-serial two's-complement add/sub, LSB-first: w_SUM 1 cycle after each digit, b_RESULT/w_DONE 1 cycle after the last digit; no backpressure.
// Define SERIAL_ADDER_OVF_EN to register a signed-overflow flag on w_OVF (tied 0 otherwise).
module serial_adder_subtractor #(
    parameter int WORD_LENGTH = 32,
    parameter int CNT_W       = $clog2(WORD_LENGTH)
) (
    input  logic                 w_CLK,
    input  logic                 w_RST,
    input  logic                 w_START,
    input  logic                 w_A,
    input  logic                 w_B,
    input  logic                 w_SUB,
    output logic                 w_SUM,
    output logic                 w_BUSY,
    output logic                 w_DONE,
    output logic                 w_CARRY_OUT,
    output logic [0:WORD_LENGTH-1] b_RESULT,
    output logic                 w_OVF
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]             state;
    logic [CNT_W-1:0]       cnt;
    logic                   carry_q;
    logic                   mode;
    logic [0:WORD_LENGTH-1] shadow;

    logic                   mode_eff;
    logic                   b_eff;
    logic                   cin;
    logic                   s;
    logic                   cnew;
    logic                   last;
    logic [0:WORD_LENGTH-1] shadow_next;

    // w_START always wins: it restarts the word using the freshly sampled mode.
    always_comb begin
        mode_eff    = w_START ? w_SUB : mode;
        b_eff       = w_B ^ mode_eff;
        cin         = w_START ? w_SUB : carry_q;
        s           = w_A ^ b_eff ^ cin;
        cnew        = (w_A & b_eff) | (w_A & cin) | (b_eff & cin);
        last        = (state == RUN) && !w_START && (cnt == CNT_W'(WORD_LENGTH - 1));
        shadow_next = shadow;
        if (w_START) begin
            shadow_next[0] = s;
        end else if (state == RUN) begin
            shadow_next[cnt] = s;
        end
    end

    assign w_BUSY = (state == RUN);

    always_ff @(posedge w_CLK) begin
        if (w_RST) begin
            state       <= IDLE;
            cnt         <= '0;
            carry_q     <= 1'b0;
            mode        <= 1'b0;
            shadow      <= '0;
            w_SUM       <= 1'b0;
            w_DONE      <= 1'b0;
            w_CARRY_OUT <= 1'b0;
            b_RESULT    <= '0;
        end else begin
            w_DONE <= 1'b0;
            w_SUM  <= 1'b0;
            if (w_START) begin
                mode    <= w_SUB;
                carry_q <= cnew;
                shadow  <= shadow_next;
                w_SUM   <= s;
                cnt     <= CNT_W'(1);
                state   <= RUN;
            end else if (state == RUN) begin
                carry_q <= cnew;
                shadow  <= shadow_next;
                w_SUM   <= s;
                cnt     <= cnt + 1'b1;
                if (last) begin
                    b_RESULT    <= shadow_next;
                    w_CARRY_OUT <= cnew;
                    w_DONE      <= 1'b1;
                    cnt         <= '0;
                    state       <= IDLE;
                end
            end
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    // On the MSB digit the carry FF holds the carry into the MSB.
    always_ff @(posedge w_CLK) begin
        if (w_RST) begin
            w_OVF <= 1'b0;
        end else if (last) begin
            w_OVF <= carry_q ^ cnew;
        end
    end
`else
    assign w_OVF = 1'b0;
`endif

endmodule

// File: tb/tb_serial_adder_subtractor.sv
// Randomised and directed checks of serial_adder_subtractor (WORD_LENGTH=5) against an integer arithmetic model.
module tb_serial_adder_subtractor;

    localparam int WL = 5;

    logic clk = 1'b0;
    logic rst, start, a, b, sub;
    logic sum, busy, done, cout, ovf;
    logic [0:WL-1] result;

    int tests = 0;
    int fails = 0;

    logic [WL-1:0] obs_sum;
    int busy_bad;
    int done_seen;

    serial_adder_subtractor #(.WORD_LENGTH(WL)) dut (
        .w_CLK(clk), .w_RST(rst), .w_START(start), .w_A(a), .w_B(b), .w_SUB(sub),
        .w_SUM(sum), .w_BUSY(busy), .w_DONE(done), .w_CARRY_OUT(cout),
        .b_RESULT(result), .w_OVF(ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [WL-1:0] res_val();
        logic [WL-1:0] v;
        for (int i = 0; i < WL; i++) v[i] = result[i];
        return v;
    endfunction

    // Returns {ovf, carry, result} from plain integer arithmetic.
    function automatic logic [WL+1:0] model(input logic [WL-1:0] av, input logic [WL-1:0] bv, input logic sv);
        int ua, ub, raw, sa, sb, sres;
        logic [WL-1:0] r;
        logic c, o;
        ua = int'(av);
        ub = int'(bv);
        raw = sv ? ua + (32 - ub) : ua + ub;
        r = WL'(raw % 32);
        c = (raw >= 32);
        sa = (ua >= 16) ? ua - 32 : ua;
        sb = (ub >= 16) ? ub - 32 : ub;
        sres = sv ? sa - sb : sa + sb;
`ifdef SERIAL_ADDER_OVF_EN
        o = (sres > 15) || (sres < -16);
`else
        o = 1'b0;
`endif
        return {o, c, r};
    endfunction

    // Drives digits 0..n-1 of a word starting now; records w_SUM of digits 0..n-2.
    task automatic drive_word(input logic [WL-1:0] av, input logic [WL-1:0] bv, input logic sv, input int n);
        start = 1'b1; a = av[0]; b = bv[0]; sub = sv;
        for (int k = 1; k < n; k++) begin
            @(negedge clk);
            obs_sum[k-1] = sum;
            if (!busy) busy_bad++;
            if (done) done_seen++;
            start = 1'b0; a = av[k]; b = bv[k]; sub = 1'($urandom);
        end
    endtask

    task automatic go_idle();
        start = 1'b0; a = 1'($urandom); b = 1'($urandom); sub = 1'($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = 1'b1; b = 1'b1; sub = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if ({sum, busy, done, cout, ovf} !== 5'b0 || res_val() !== '0) begin
            fails++;
            $display("FAIL reset: sum/busy/done/cout/ovf=%b result=%0d, required all 0", {sum, busy, done, cout, ovf}, res_val());
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [WL-1:0] ta [5] = '{5'd1, 5'd3, 5'd5, 5'd31, 5'd15};
        logic [WL-1:0] tb [5] = '{5'd7, 5'd5, 5'd3, 5'd1, 5'd1};
        logic          ts [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [WL-1:0] tr [5] = '{5'd8, 5'd30, 5'd2, 5'd0, 5'd16};
        logic          tc [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic          to [5];
        logic [WL-1:0] held;
`ifdef SERIAL_ADDER_OVF_EN
        to = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`else
        to = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
        for (int i = 0; i < 5; i++) begin
            busy_bad = 0; done_seen = 0;
            @(negedge clk);
            drive_word(ta[i], tb[i], ts[i], WL);
            @(negedge clk);
            obs_sum[WL-1] = sum;
            go_idle();
            tests++;
            if (done !== 1'b1 || busy !== 1'b0 || busy_bad != 0 || done_seen != 0) begin
                fails++;
                $display("FAIL directed%0d timing: done=%b busy=%b busy_gaps=%0d early_done=%0d, required done=1 busy=0 0 0",
                         i, done, busy, busy_bad, done_seen);
            end
            tests++;
            if (res_val() !== tr[i] || cout !== tc[i] || ovf !== to[i]) begin
                fails++;
                $display("FAIL directed%0d result: res=%0d cout=%b ovf=%b, required res=%0d cout=%b ovf=%b",
                         i, res_val(), cout, ovf, tr[i], tc[i], to[i]);
            end
            tests++;
            if (obs_sum !== tr[i]) begin
                fails++;
                $display("FAIL directed%0d sum_stream: got %b, required %b (MSB..LSB)", i, obs_sum, tr[i]);
            end
            held = tr[i];
            repeat (2) @(negedge clk);
            tests++;
            if (done !== 1'b0 || sum !== 1'b0 || busy !== 1'b0 || res_val() !== held || cout !== tc[i]) begin
                fails++;
                $display("FAIL directed%0d idle_hold: done=%b sum=%b busy=%b res=%0d cout=%b, required 0 0 0 %0d %b",
                         i, done, sum, busy, res_val(), cout, held, tc[i]);
            end
        end
    endtask

    task automatic test_abort();
        int cut [2] = '{2, 4};
        logic [WL-1:0] a1, b1, a2, b2, prev;
        logic s1, s2;
        logic [WL+1:0] exp;
        for (int i = 0; i < 2; i++) begin
            a1 = WL'($urandom); b1 = WL'($urandom); s1 = 1'($urandom);
            a2 = WL'($urandom); b2 = WL'($urandom); s2 = 1'($urandom);
            exp = model(a2, b2, s2);
            prev = res_val();
            busy_bad = 0; done_seen = 0;
            @(negedge clk);
            drive_word(a1, b1, s1, cut[i]);
            @(negedge clk);
            tests++;
            if (done !== 1'b0 || res_val() !== prev) begin
                fails++;
                $display("FAIL abort%0d restart: done=%b res=%0d, required done=0 res=%0d", i, done, res_val(), prev);
            end
            drive_word(a2, b2, s2, WL);
            @(negedge clk);
            obs_sum[WL-1] = sum;
            go_idle();
            tests++;
            if (done !== 1'b1 || done_seen != 0 || busy_bad != 0 || {ovf, cout, res_val()} !== exp || obs_sum !== exp[WL-1:0]) begin
                fails++;
                $display("FAIL abort%0d second_word: done=%b early_done=%0d {ovf,cout,res}=%b sum=%b, required done=1 0 %b sum=%b",
                         i, done, done_seen, {ovf, cout, res_val()}, obs_sum, exp, exp[WL-1:0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [WL-1:0] av [2] = '{5'd9, 5'd4};
        logic [WL-1:0] bv [2] = '{5'd30, 5'd12};
        logic          sv [2] = '{1'b0, 1'b1};
        logic [WL+1:0] exp;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            busy_bad = 0; done_seen = 0;
            drive_word(av[i], bv[i], sv[i], WL);
            @(negedge clk);
            obs_sum[WL-1] = sum;
            exp = model(av[i], bv[i], sv[i]);
            tests++;
            if (done !== 1'b1 || done_seen != 0 || busy_bad != 0 || {ovf, cout, res_val()} !== exp || obs_sum !== exp[WL-1:0]) begin
                fails++;
                $display("FAIL b2b word%0d: done=%b early_done=%0d busy_gaps=%0d {ovf,cout,res}=%b sum=%b, required done=1 0 0 %b sum=%b",
                         i, done, done_seen, busy_bad, {ovf, cout, res_val()}, obs_sum, exp, exp[WL-1:0]);
            end
        end
        go_idle();
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        drive_word(5'd31, 5'd31, 1'b0, WL);
        @(negedge clk);
        go_idle();
        @(negedge clk);
        drive_word(5'd31, 5'd31, 1'b0, 3);
        @(negedge clk);
        rst = 1'b1; start = 1'b0;
        @(negedge clk);
        tests++;
        if ({sum, busy, done, cout, ovf} !== 5'b0 || res_val() !== '0) begin
            fails++;
            $display("FAIL reset_mid: sum/busy/done/cout/ovf=%b res=%0d, required all 0", {sum, busy, done, cout, ovf}, res_val());
        end
        rst = 1'b0;
        done_seen = 0;
        repeat (WL + 1) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        tests++;
        if (done_seen != 0) begin
            fails++;
            $display("FAIL reset_mid discarded_word: done pulses=%0d, required 0", done_seen);
        end
        busy_bad = 0;
        drive_word(5'd0, 5'd0, 1'b0, WL);
        @(negedge clk);
        obs_sum[WL-1] = sum;
        go_idle();
        tests++;
        if (done !== 1'b1 || res_val() !== '0 || cout !== 1'b0 || obs_sum !== '0) begin
            fails++;
            $display("FAIL reset_mid zero_word: done=%b res=%0d cout=%b sum=%b, required 1 0 0 00000", done, res_val(), cout, obs_sum);
        end
    endtask

    task automatic test_random();
        logic [WL-1:0] av, bv;
        logic sv;
        logic [WL+1:0] exp;
        int gap;
        @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            av = WL'($urandom); bv = WL'($urandom); sv = 1'($urandom);
            exp = model(av, bv, sv);
            busy_bad = 0; done_seen = 0;
            drive_word(av, bv, sv, WL);
            @(negedge clk);
            obs_sum[WL-1] = sum;
            tests++;
            if (done !== 1'b1 || done_seen != 0 || busy_bad != 0 || {ovf, cout, res_val()} !== exp || obs_sum !== exp[WL-1:0]) begin
                fails++;
                $display("FAIL random%0d a=%0d b=%0d sub=%b: done=%b {ovf,cout,res}=%b sum=%b, required done=1 %b sum=%b",
                         i, av, bv, sv, done, {ovf, cout, res_val()}, obs_sum, exp, exp[WL-1:0]);
            end
            gap = $urandom_range(0, 2);
            if (gap > 0) begin
                go_idle();
                repeat (gap) @(negedge clk);
            end
        end
        go_idle();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
